// File: rtl/timer_pkg.sv
// Shared command and state encodings for the interval timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Counter datapath for the interval timer: synchronous clear has priority over enable.
module timer_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// Command-driven interval timer: FSM, prescaler, terminal compare and outputs.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_period,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  input  logic                  cmd_periodic,
  output logic [WIDTH-1:0]      count,
  output logic                  expire,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q,    state_d;
  logic [WIDTH-1:0]      period_q,   period_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  periodic_q, periodic_d;
  logic [PRESCALE_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic                  expire_q,   expire_d;
  logic                  done_q,     done_d;

  logic cmd_acc;
  logic cnt_clr;
  logic cnt_en;
  logic step;
  op_t  op;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state_q != ST_LOAD);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign step      = (state_q == ST_RUN) && (pre_cnt_q == prescale_q);

  // Next-state logic; an accepted START/CLEAR/STOP-in-RUN pre-empts any step due this cycle.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    pre_cnt_d  = pre_cnt_q;
    expire_d   = 1'b0;
    done_d     = done_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    if (cmd_acc && op == OP_START) begin
      state_d    = ST_LOAD;
      period_d   = cmd_period;
      prescale_d = cmd_prescale;
      periodic_d = cmd_periodic;
      done_d     = 1'b0;
    end else if (cmd_acc && op == OP_CLEAR) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      done_d  = 1'b0;
    end else if (cmd_acc && op == OP_STOP && state_q == ST_RUN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          cnt_clr   = 1'b1;
          pre_cnt_d = '0;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          if (step) begin
            pre_cnt_d = '0;
            if (count != period_q) begin
              cnt_en = 1'b1;
            end else begin
              expire_d = 1'b1;
              if (periodic_q) begin
                cnt_clr = 1'b1;
              end else begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      pre_cnt_q  <= '0;
      expire_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      pre_cnt_q  <= pre_cnt_d;
      expire_q   <= expire_d;
      done_q     <= done_d;
    end
  end

  timer_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  assign expire = expire_q;
  assign done   = done_q;
  assign busy   = (state_q == ST_LOAD) || (state_q == ST_RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_period;
  logic [3:0] cmd_prescale;
  logic       cmd_periodic;
  logic [7:0] count;
  logic       expire;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  timer_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_period   (cmd_period),
    .cmd_prescale (cmd_prescale),
    .cmd_periodic (cmd_periodic),
    .count        (count),
    .expire       (expire),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Present a command for one cycle; returns 1ns after the accepting edge (start of cycle 1).
  task automatic issue(input logic [1:0] op, input logic [7:0] p, input logic [3:0] s,
                       input logic per);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_period   = p;
    cmd_prescale = s;
    cmd_periodic = per;
    @(posedge clk);
    #1;
    cmd_valid    = 1'b0;
    cmd_op       = 2'd0;
    cmd_period   = 8'd0;
    cmd_prescale = 4'd0;
    cmd_periodic = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 8'd0; cmd_prescale = 4'd0; cmd_periodic = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || expire !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d busy=%b done=%b ready=%b expire=%b, want 0 0 0 1 0",
               count, busy, done, cmd_ready, expire);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    issue(2'd1, 8'd10, 4'd0, 1'b0);
    repeat (7) @(negedge clk);   // cycle 7: count 5
    checks++;
    if (count !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre: count=%0d busy=%b, want 5 1", count, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || expire !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: count=%0d busy=%b done=%b ready=%b expire=%b, want 0 0 0 1 0",
               count, busy, done, cmd_ready, expire);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oneshot();
    issue(2'd1, 8'd3, 4'd0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 2 && count !== ((c <= 2) ? 8'd0 : (c <= 5) ? 8'(c - 2) : 8'd3)) begin
        errors++;
        $display("FAIL oneshot_count c%0d: got %0d want %0d", c, count,
                 (c <= 2) ? 0 : (c <= 5) ? c - 2 : 3);
      end
      if (expire !== (c == 6) || done !== (c >= 6) || busy !== (c <= 5) || cmd_ready !== (c != 1)) begin
        errors++;
        $display("FAIL oneshot_flags c%0d: expire=%b done=%b busy=%b ready=%b want %b %b %b %b",
                 c, expire, done, busy, cmd_ready, c == 6, c >= 6, c <= 5, c != 1);
      end
    end
  endtask

  task automatic test_periodic_prescale();
    issue(2'd1, 8'd1, 4'd2, 1'b1);
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      checks++;
      if (c >= 2 && count !== 8'(((c - 2) / 3) % 2)) begin
        errors++;
        $display("FAIL periodic_count c%0d: got %0d want %0d", c, count, ((c - 2) / 3) % 2);
      end
      if (expire !== (c >= 8 && (c - 2) % 6 == 0) || done !== 1'b0) begin
        errors++;
        $display("FAIL periodic_expire c%0d: expire=%b done=%b want %b 0",
                 c, expire, done, c >= 8 && (c - 2) % 6 == 0);
      end
    end
    issue(2'd3, 8'd0, 4'd0, 1'b0);
  endtask

  task automatic test_period_zero();
    issue(2'd1, 8'd0, 4'd0, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if ((c >= 2 && count !== 8'd0) || expire !== (c >= 3) || busy !== 1'b1) begin
        errors++;
        $display("FAIL p0 c%0d: count=%0d expire=%b busy=%b want 0 %b 1", c, count, expire, busy, c >= 3);
      end
    end
    issue(2'd3, 8'd0, 4'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 8'd0 || expire !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL p0_clear: count=%0d expire=%b busy=%b want 0 0 0", count, expire, busy);
    end
  endtask

  task automatic test_stop_clear();
    issue(2'd1, 8'd10, 4'd0, 1'b0);
    repeat (4) @(negedge clk);    // cycle 4: count 2
    checks++;
    if (count !== 8'd2) begin
      errors++;
      $display("FAIL stop_pre: count=%0d want 2", count);
    end
    issue(2'd2, 8'd0, 4'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (count !== 8'd2 || busy !== 1'b0 || expire !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL stopped %0d: count=%0d busy=%b expire=%b done=%b ready=%b want 2 0 0 0 1",
                 c, count, busy, expire, done, cmd_ready);
      end
    end
    issue(2'd0, 8'd0, 4'd0, 1'b0);   // NOP
    @(negedge clk);
    checks++;
    if (count !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nop_idle: count=%0d busy=%b want 2 0", count, busy);
    end
    issue(2'd3, 8'd0, 4'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear: count=%0d busy=%b want 0 0", count, busy);
    end
    issue(2'd2, 8'd0, 4'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (count !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1 || expire !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: count=%0d busy=%b ready=%b expire=%b want 0 0 1 0",
               count, busy, cmd_ready, expire);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'd1, 8'd2, 4'd0, 1'b0);
    repeat (4) @(negedge clk);    // cycle 4: count 2, expiring step due
    checks++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre: count=%0d busy=%b want 2 1", count, busy);
    end
    issue(2'd1, 8'd1, 4'd0, 1'b1);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      checks++;
      if (n >= 2 && count !== 8'((n - 2) % 2)) begin
        errors++;
        $display("FAIL b2b_count n%0d: got %0d want %0d", n, count, (n - 2) % 2);
      end
      if (expire !== (n == 4 || n == 6) || done !== 1'b0 || cmd_ready !== (n != 1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_flags n%0d: expire=%b done=%b ready=%b busy=%b want %b 0 %b 1",
                 n, expire, done, cmd_ready, busy, n == 4 || n == 6, n != 1);
      end
    end
    issue(2'd3, 8'd0, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_oneshot();
    test_periodic_prescale();
    test_period_zero();
    test_stop_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
